receiver: RTL and testbench
===========================

# receiver

Serial command receiver for the logic analyzer's host link, the inbound counterpart of the 8N1 sample transmitter. It deserializes 8N1 bytes from `rx` and assembles them into SUMP commands. Short commands are one opcode byte. Long commands are one opcode byte followed by four data bytes. Each complete command is presented to the core controller as a single-cycle `execute` strobe with `opcode`/`opdata`.

## Interface
- `FREQ`, 100000000: system clock frequency in Hz.
- `BAUDRATE`, 115200: serial bit rate.
- `BITLENGTH`, FREQ/BAUDRATE: `trxClock` ticks per bit. Legal range 4..1023 (10-bit counter).
- `TIMEOUT_BITS`, 100: inter-byte timeout in bit periods. Used only with `RECEIVER_TIMEOUT_EN`.

Ports:
- `clock` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `trxClock` in 1: baud-tick enable. The counter advances only on cycles where this is high.
- `rx` in 1: asynchronous serial input, idle high.
- `execute` out 1: one-cycle strobe, a command is complete.
- `opcode` out 8: opcode of the last completed command.
- `opdata` out 32: data of the last completed long command. Byte 1 lands in `[7:0]`, byte 4 in `[31:24]`.
- `frameError` out 1: one-cycle strobe when a stop bit samples low.

## Operation
- `rx` passes through a 2-flop synchronizer before any use. This adds 2 cycles of latency.
- Byte FSM states:
  - IDLE: a synchronized `rx` of 0 → START, counter cleared.
  - START: after BITLENGTH/2 ticks (integer division), sample `rx`. If 0 → DATA with bit index 0. If 1, it was a glitch → IDLE with no byte.
  - DATA: every BITLENGTH ticks, sample into the shift register, LSB first. After bit index 7 → STOP.
  - STOP: after BITLENGTH ticks, sample `rx`. If 1, the byte is valid → IDLE. If 0, pulse `frameError`, discard the byte, discard any partial command, → BREAK.
  - BREAK: wait for `rx` = 1, then → IDLE. A held-low line (break) produces exactly one `frameError`.
- Command assembly:
  - `bytecount` is 0..4.
  - A valid byte at `bytecount` 0 becomes the opcode.
  - If opcode bit 7 = 0 (short command): pulse `execute`; `opdata` is unchanged.
  - If opcode bit 7 = 1 (long command): collect 4 more bytes, then pulse `execute` and update `opdata`.
  - `opcode`/`opdata` update in the same cycle `execute` rises. They hold until the next `execute`.
- The counter counts `trxClock` ticks and clears on every FSM transition. Compare for equality; never wrap.
- Reset values: `execute`=0, `frameError`=0, `opcode`=0x00, `opdata`=0x00000000, FSM=IDLE, `bytecount`=0, synchronizer flops=1.

## Timing
- `execute` rises on the clock edge after the valid stop-bit sample of the final byte.
- `execute` and `frameError` are high for exactly one `clock` cycle, regardless of `trxClock`.
- The earliest detectable start edge is 1 tick after STOP→IDLE. Back-to-back bytes with no idle time are accepted.
- With `trxClock` held low, the FSM freezes; no timeouts or samples occur.
- Reset asserted mid-byte or mid-command: the next edge returns everything to reset values. Partial data is lost and no strobe is generated.
- `execute` and `frameError` are never high in the same cycle.

## Configuration
- `RECEIVER_TIMEOUT_EN` defined: in IDLE with `bytecount` ≠ 0, count ticks. After TIMEOUT_BITS×BITLENGTH ticks with no start bit, clear `bytecount`. No strobe is generated. The timer resets on every start detection.
- `RECEIVER_TIMEOUT_EN` undefined: no timer logic, and `TIMEOUT_BITS` is ignored. A partial long command waits indefinitely.

## Structure
- A shared package holds:
  - the byte FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - `LONG_CMD_BIT` = 7;
  - `CMD_DATA_BYTES` = 4;
  - `SYNC_STAGES` = 2.
- Sub-module `uart_rx_byte`: synchronizer, counter and byte FSM. Its outputs are `byteValid`, `rxByte[7:0]` and `frameError`.
- The top level holds `bytecount`, the command registers, and the optional timeout.

## Test plan
- Bench settings for all scenarios: BITLENGTH=16, `trxClock`=1.
- Short command: send 0x01 → one `execute` pulse with `opcode`=0x01 and `opdata`=0x00000000.
- Long command: send 0xC0,0x78,0x56,0x34,0x12 back-to-back → one `execute` with `opcode`=0xC0 and `opdata`=0x12345678. No `execute` after the earlier bytes.
- Glitch: drive `rx` low for 4 cycles, then high → no `execute`, no `frameError`, FSM back in IDLE. Then send 0x02 → `opcode`=0x02.
- Framing error: send 0x80,0x11, then 0x22 with a low stop bit → one `frameError`, no `execute`. Then send 0x00 → `execute` with `opcode`=0x00.
- Reset mid-command: send 0x80,0xAA, assert `reset` 1 cycle during byte 3 → all outputs at reset values. Then send 0x03 → `opcode`=0x03.
- `RECEIVER_TIMEOUT_EN`, TIMEOUT_BITS=10: send 0x82, idle 200 cycles, send 0x04 → `execute` with `opcode`=0x04, not a long-command completion.

Source files
------------

// File: rtl/receiver_pkg.sv
// Shared types and constants for the SUMP command receiver.
package receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int LONG_CMD_BIT   = 7;
    localparam int CMD_DATA_BYTES = 4;
    localparam int SYNC_STAGES    = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserializer: input synchronizer, baud-tick counter and byte FSM.
module uart_rx_byte
    import receiver_pkg::*;
#(
    parameter int BITLENGTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trxClock,
    input  logic       rx,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       frameError,
    output logic       lineIdle
);

    localparam logic [9:0] FULL_LAST = 10'(BITLENGTH - 1);
    localparam logic [9:0] HALF_LAST = 10'(BITLENGTH / 2 - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    rx_state_t              state;
    logic [9:0]             cnt;
    logic [2:0]             bitidx;
    logic [7:0]             shreg;

    assign rx_s     = sync[SYNC_STAGES-1];
    assign lineIdle = (state == ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], rx};
    end

    // Strobes default low every cycle so they last exactly one clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            rxByte     <= '0;
            byteValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            byteValid  <= 1'b0;
            frameError <= 1'b0;
            if (trxClock) begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                        if (!rx_s) state <= ST_START;
                    end
                    ST_START: begin
                        if (cnt == HALF_LAST) begin
                            cnt    <= '0;
                            bitidx <= '0;
                            state  <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt    <= '0;
                            shreg  <= {rx_s, shreg[7:1]};
                            bitidx <= bitidx + 3'd1;
                            if (bitidx == 3'd7) state <= ST_STOP;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                rxByte    <= shreg;
                                byteValid <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                frameError <= 1'b1;
                                state      <= ST_BREAK;
                            end
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                    ST_BREAK: begin
                        cnt <= '0;
                        if (rx_s) state <= ST_IDLE;
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// SUMP command assembler on top of an 8N1 byte receiver.
// Optional inter-byte timeout enabled by defining RECEIVER_TIMEOUT_EN.
module receiver
    import receiver_pkg::*;
#(
    parameter int FREQ         = 100000000,
    parameter int BAUDRATE     = 115200,
    parameter int BITLENGTH    = FREQ / BAUDRATE,
    parameter int TIMEOUT_BITS = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trxClock,
    input  logic        rx,
    output logic        execute,
    output logic [7:0]  opcode,
    output logic [31:0] opdata,
    output logic        frameError
);

    if (BITLENGTH < 4 || BITLENGTH > 1023 || TIMEOUT_BITS < 1) begin : g_bad_param
        $error("receiver: BITLENGTH must be 4..1023 and TIMEOUT_BITS >= 1");
    end

    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        byte_fe;
    logic        line_idle;
    logic [2:0]  bytecount;
    logic [7:0]  cmd_op;
    logic [31:0] data_buf;
    logic        timeout_hit;

    uart_rx_byte #(.BITLENGTH(BITLENGTH)) u_byte (
        .clock     (clock),
        .reset     (reset),
        .trxClock  (trxClock),
        .rx        (rx),
        .byteValid (byte_valid),
        .rxByte    (rx_byte),
        .frameError(byte_fe),
        .lineIdle  (line_idle)
    );

`ifdef RECEIVER_TIMEOUT_EN
    localparam int TIMEOUT_TICKS = TIMEOUT_BITS * BITLENGTH;
    localparam int TW            = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] timer;

    assign timeout_hit = trxClock && line_idle && (bytecount != 3'd0) &&
                         (timer == TW'(TIMEOUT_TICKS - 1));

    // Runs only while a partial command sits in an idle line.
    always_ff @(posedge clock) begin
        if (reset || !line_idle || bytecount == 3'd0 || timeout_hit) timer <= '0;
        else if (trxClock)                                        timer <= timer + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            bytecount  <= '0;
            cmd_op     <= '0;
            data_buf   <= '0;
            opcode     <= '0;
            opdata     <= '0;
            execute    <= 1'b0;
            frameError <= 1'b0;
        end else begin
            execute    <= 1'b0;
            frameError <= byte_fe;
            if (byte_fe) begin
                bytecount <= '0;
            end else if (byte_valid) begin
                if (bytecount == 3'd0) begin
                    if (rx_byte[LONG_CMD_BIT]) begin
                        cmd_op    <= rx_byte;
                        bytecount <= 3'd1;
                    end else begin
                        opcode  <= rx_byte;
                        execute <= 1'b1;
                    end
                end else if (bytecount == 3'(CMD_DATA_BYTES)) begin
                    opcode    <= cmd_op;
                    opdata    <= {rx_byte, data_buf[31:8]};
                    execute   <= 1'b1;
                    bytecount <= '0;
                end else begin
                    data_buf  <= {rx_byte, data_buf[31:8]};
                    bytecount <= bytecount + 3'd1;
                end
            end else if (timeout_hit) begin
                bytecount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: BITLENGTH=16, trxClock tied high.
module tb_receiver;

    localparam int BL = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        trxClock = 1'b1;
    logic        rx = 1'b1;
    logic        execute;
    logic [7:0]  opcode;
    logic [31:0] opdata;
    logic        frameError;

    int n_chk  = 0;
    int n_pass = 0;
    int exec_cnt = 0;
    int fe_cnt   = 0;
    logic [39:0] sb[$];

    receiver #(.FREQ(1600), .BAUDRATE(100), .BITLENGTH(BL), .TIMEOUT_BITS(10)) dut (
        .clock     (clock),
        .reset     (reset),
        .trxClock  (trxClock),
        .rx        (rx),
        .execute   (execute),
        .opcode    (opcode),
        .opdata    (opdata),
        .frameError(frameError)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (execute || frameError)
                chk("exec_fe_exclusive", 64'(execute & frameError), 64'd0);
            if (frameError) fe_cnt++;
            if (execute) begin
                exec_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_exec", 64'(sb.size()), 64'd1);
                end else begin
                    logic [39:0] e;
                    e = sb.pop_front();
                    chk("opcode", 64'(opcode), 64'(e[39:32]));
                    chk("opdata", 64'(opdata), 64'(e[31:0]));
                end
            end
        end
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BL) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_execute", 64'(execute), 64'd0);
        chk("rst_fe", 64'(frameError), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_opdata", 64'(opdata), 64'd0);
        reset = 1'b0;
        idle(20);

        // Short command
        sb.push_back({8'h01, 32'h0});
        send_byte(8'h01, 1'b1);
        idle(40);
        chk("short_exec_cnt", 64'(exec_cnt), 64'd1);

        // Long command, back-to-back bytes
        sb.push_back({8'hC0, 32'h12345678});
        send_byte(8'hC0, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("long_no_early_exec", 64'(exec_cnt), 64'd1);
        send_byte(8'h12, 1'b1);
        idle(40);
        chk("long_exec_cnt", 64'(exec_cnt), 64'd2);

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) @(negedge clock);
        idle(60);
        chk("glitch_exec_cnt", 64'(exec_cnt), 64'd2);
        chk("glitch_fe_cnt", 64'(fe_cnt), 64'd0);
        sb.push_back({8'h02, 32'h12345678});
        send_byte(8'h02, 1'b1);
        idle(40);
        chk("glitch_then_exec", 64'(exec_cnt), 64'd3);

        // Framing error drops partial long command
        send_byte(8'h80, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(40);
        chk("fe_cnt", 64'(fe_cnt), 64'd1);
        chk("fe_no_exec", 64'(exec_cnt), 64'd3);
        sb.push_back({8'h00, 32'h12345678});
        send_byte(8'h00, 1'b1);
        idle(40);
        chk("fe_then_exec", 64'(exec_cnt), 64'd4);

        // Reset mid-command, during byte 3
        send_byte(8'h80, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_execute", 64'(execute), 64'd0);
        chk("midrst_fe", 64'(frameError), 64'd0);
        chk("midrst_opcode", 64'(opcode), 64'd0);
        chk("midrst_opdata", 64'(opdata), 64'd0);
        reset = 1'b0;
        idle(300);
        chk("midrst_no_exec", 64'(exec_cnt), 64'd4);
        sb.push_back({8'h03, 32'h0});
        send_byte(8'h03, 1'b1);
        idle(40);
        chk("midrst_then_exec", 64'(exec_cnt), 64'd5);

`ifdef RECEIVER_TIMEOUT_EN
        // Inter-byte timeout discards partial long command
        send_byte(8'h82, 1'b1);
        idle(200);
        sb.push_back({8'h04, 32'h0});
        send_byte(8'h04, 1'b1);
        idle(40);
        chk("timeout_exec_cnt", 64'(exec_cnt), 64'd6);
`endif

        idle(20);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("fe_total", 64'(fe_cnt), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
